// File: rtl/io_tile_cfg_array.sv
// rtl/io_tile_cfg_array.sv - configurable I/O tile: serial config chain, per-pad direction/register/polarity
module io_tile_cfg_array #(
  parameter int NUM_IO = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_done,
  input  logic [NUM_IO-1:0] fabric_outpad,
  output logic [NUM_IO-1:0] fabric_inpad,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe
);

  localparam int CHAIN_LEN = 4 * NUM_IO;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] chain;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_IO-1:0]    ireg_q;
  logic [NUM_IO-1:0]    oreg_q;
  logic [NUM_IO-1:0]    d_o;
  logic [NUM_IO-1:0]    d_i;
  logic [NUM_IO-1:0]    cfg_oe;
  logic [NUM_IO-1:0]    cfg_ireg;
  logic [NUM_IO-1:0]    cfg_oreg;
  logic [NUM_IO-1:0]    cfg_inv;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      chain <= '0;
      cnt   <= '0;
    end else if (ccff_en) begin
      chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      // A new shift burst after a completed load restarts the count at 1.
      cnt   <= (cnt == CNT_FULL) ? CNT_W'(1) : cnt + CNT_W'(1);
    end
  end

  assign ccff_tail = chain[CHAIN_LEN-1];
  assign cfg_done  = (cnt == CNT_FULL) && !ccff_en;

  always_comb begin
    for (int i = 0; i < NUM_IO; i++) begin
      cfg_oe[i]   = chain[4*i];
      cfg_ireg[i] = chain[4*i+1];
      cfg_oreg[i] = chain[4*i+2];
      cfg_inv[i]  = chain[4*i+3];
    end
  end

  assign d_o = fabric_outpad ^ cfg_inv;
  assign d_i = pad_in ^ cfg_inv;

  // Pipeline registers only track data once the tile is configured.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      ireg_q <= '0;
      oreg_q <= '0;
    end else if (cfg_done) begin
      ireg_q <= d_i;
      oreg_q <= d_o;
    end
  end

  always_comb begin
    pad_out      = '0;
    pad_oe       = '0;
    fabric_inpad = '0;
    if (cfg_done) begin
      pad_out      = (cfg_oreg & oreg_q) | (~cfg_oreg & d_o);
      pad_oe       = cfg_oe;
      fabric_inpad = (cfg_ireg & ireg_q) | (~cfg_ireg & d_i);
    end
  end

endmodule

// File: tb/tb_io_tile_cfg_array.sv
// tb/tb_io_tile_cfg_array.sv - randomized self-checking bench for io_tile_cfg_array
module tb_io_tile_cfg_array;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       ccff_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic       cfg_done;
  logic [7:0] fabric_outpad;
  logic [7:0] fabric_inpad;
  logic [7:0] pad_in;
  logic [7:0] pad_out;
  logic [7:0] pad_oe;

  int passed = 0;
  int total  = 0;

  io_tile_cfg_array #(.NUM_IO(8)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .ccff_en       (ccff_en),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .cfg_done      (cfg_done),
    .fabric_outpad (fabric_outpad),
    .fabric_inpad  (fabric_inpad),
    .pad_in        (pad_in),
    .pad_out       (pad_out),
    .pad_oe        (pad_oe)
  );

  always #5 prog_clk = ~prog_clk;

  // Reference model: the bit stream shifted since reset plus the two data registers.
  logic       stream_m[$];
  int         nshift;
  logic [7:0] ireg_m;
  logic [7:0] oreg_m;

  function automatic void model_reset();
    stream_m.delete();
    nshift = 0;
    ireg_m = '0;
    oreg_m = '0;
  endfunction

  // Chain bit j holds the bit shifted in j shifts ago.
  function automatic logic [31:0] chain_m();
    logic [31:0] c = '0;
    int sz = stream_m.size();
    for (int j = 0; j < 32; j++)
      if (sz - 1 - j >= 0) c[j] = stream_m[sz-1-j];
    return c;
  endfunction

  function automatic int cnt_m();
    return (nshift == 0) ? 0 : ((nshift - 1) % 32) + 1;
  endfunction

  function automatic logic done_m();
    return (cnt_m() == 32) && !ccff_en;
  endfunction

  function automatic logic [7:0] exp_pad_out();
    logic [31:0] c = chain_m();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      logic d = fabric_outpad[i] ^ c[4*i+3];
      r[i] = done_m() ? (c[4*i+2] ? oreg_m[i] : d) : 1'b0;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_pad_oe();
    logic [31:0] c = chain_m();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = done_m() & c[4*i];
    return r;
  endfunction

  function automatic logic [7:0] exp_fabric_inpad();
    logic [31:0] c = chain_m();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      logic d = pad_in[i] ^ c[4*i+3];
      r[i] = done_m() ? (c[4*i+1] ? ireg_m[i] : d) : 1'b0;
    end
    return r;
  endfunction

  // Advance one clock, updating the model from the pre-edge inputs; ends just after negedge.
  task automatic tick();
    logic        d;
    logic [31:0] c;
    logic [7:0]  no, ni;
    d = done_m();
    c = chain_m();
    for (int i = 0; i < 8; i++) begin
      no[i] = fabric_outpad[i] ^ c[4*i+3];
      ni[i] = pad_in[i] ^ c[4*i+3];
    end
    @(posedge prog_clk);
    if (!pReset) begin
      model_reset();
    end else begin
      if (d) begin
        oreg_m = no;
        ireg_m = ni;
      end
      if (ccff_en) begin
        stream_m.push_back(ccff_head);
        if (stream_m.size() > 32) void'(stream_m.pop_front());
        nshift++;
      end
    end
    @(negedge prog_clk);
    #1;
  endtask

  // Shift a full 32-bit image, MSB first (slice 7 bit3 first, slice 0 bit0 last).
  task automatic shift_vec(input logic [31:0] v);
    for (int k = 31; k >= 0; k--) begin
      ccff_en   = 1'b1;
      ccff_head = v[k];
      tick();
    end
    ccff_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fabric_outpad = 8'($urandom);
    pad_in        = 8'($urandom);
    ccff_en       = 1'($urandom);
    ccff_head     = 1'($urandom);
    pReset        = 1'b0;
    model_reset();
    #1;
    total++; if (ccff_tail !== 1'b0) $display("FAIL rst_tail got %b exp 0", ccff_tail); else passed++;
    total++; if (cfg_done !== 1'b0) $display("FAIL rst_done got %b exp 0", cfg_done); else passed++;
    total++; if (pad_oe !== 8'h00) $display("FAIL rst_oe got %h exp 00", pad_oe); else passed++;
    total++; if (pad_out !== 8'h00) $display("FAIL rst_pad_out got %h exp 00", pad_out); else passed++;
    total++; if (fabric_inpad !== 8'h00) $display("FAIL rst_inpad got %h exp 00", fabric_inpad); else passed++;
    tick();
    tick();
    pReset  = 1'b1;
    ccff_en = 1'b0;
    #1;
    total++; if (cfg_done !== 1'b0) $display("FAIL rel_done got %b exp 0", cfg_done); else passed++;
    total++; if (pad_oe !== 8'h00) $display("FAIL rel_oe got %h exp 00", pad_oe); else passed++;
  endtask

  task automatic test_load();
    fabric_outpad = 8'h00;
    shift_vec(32'h0000_0001);
    total++; if (cfg_done !== 1'b1) $display("FAIL load_done got %b exp 1", cfg_done); else passed++;
    fabric_outpad = 8'h01;
    #1;
    total++; if (pad_out !== 8'h01) $display("FAIL load_pad_out got %h exp 01", pad_out); else passed++;
    total++; if (pad_oe !== 8'h01) $display("FAIL load_oe got %h exp 01", pad_oe); else passed++;
    total++; if (fabric_inpad !== exp_fabric_inpad())
      $display("FAIL load_inpad got %h exp %h", fabric_inpad, exp_fabric_inpad()); else passed++;
  endtask

  task automatic test_reg_inv();
    pad_in        = 8'h00;
    fabric_outpad = 8'h00;
    shift_vec(32'h0000_00E0);
    tick();
    total++; if (fabric_inpad[1] !== 1'b1) $display("FAIL ireg_inv got %b exp 1", fabric_inpad[1]); else passed++;
    fabric_outpad = 8'h02;
    #1;
    total++; if (pad_out[1] !== 1'b1) $display("FAIL oreg_hold got %b exp 1", pad_out[1]); else passed++;
    tick();
    total++; if (pad_out[1] !== 1'b0) $display("FAIL oreg_inv got %b exp 0", pad_out[1]); else passed++;
    total++; if (pad_oe[1] !== 1'b0) $display("FAIL oreg_oe got %b exp 0", pad_oe[1]); else passed++;
    total++; if (pad_out !== exp_pad_out()) $display("FAIL oreg_model got %h exp %h", pad_out, exp_pad_out()); else passed++;
  endtask

  task automatic test_passthrough();
    logic [31:0] pat = 32'hA5A5_A5A5;
    logic [31:0] cap = '0;
    pReset = 1'b0;
    model_reset();
    tick();
    pReset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      ccff_en   = 1'b1;
      ccff_head = (k < 32) ? pat[31-k] : 1'b0;
      tick();
      total++; if (ccff_tail !== chain_m()[31])
        $display("FAIL tail_step%0d got %b exp %b", k, ccff_tail, chain_m()[31]); else passed++;
      if (k >= 31 && k <= 62) cap[31-(k-31)] = ccff_tail;
    end
    ccff_en = 1'b0;
    #1;
    total++; if (cap !== pat) $display("FAIL tail_pattern got %h exp %h", cap, pat); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      ccff_en   = 1'b1;
      ccff_head = 1'($urandom);
      tick();
    end
    pReset = 1'b0;
    model_reset();
    #1;
    total++; if (cfg_done !== 1'b0) $display("FAIL mid_rst_done got %b exp 0", cfg_done); else passed++;
    tick();
    pReset  = 1'b1;
    ccff_en = 1'b0;
    #1;
    total++; if (cfg_done !== 1'b0) $display("FAIL mid_rel_done got %b exp 0", cfg_done); else passed++;
    total++; if (pad_oe !== 8'h00) $display("FAIL mid_rel_oe got %h exp 00", pad_oe); else passed++;
    shift_vec($urandom);
    total++; if (cfg_done !== 1'b1) $display("FAIL mid_reload_done got %b exp 1", cfg_done); else passed++;
    total++; if (pad_oe !== exp_pad_oe()) $display("FAIL mid_reload_oe got %h exp %h", pad_oe, exp_pad_oe()); else passed++;
  endtask

  task automatic test_reconfig();
    logic [31:0] v = $urandom | 32'h1111_1111;
    shift_vec(32'hFFFF_FFF1);
    pad_in = 8'hFF;
    #1;
    total++; if (cfg_done !== 1'b1) $display("FAIL recfg_pre_done got %b exp 1", cfg_done); else passed++;
    ccff_en   = 1'b1;
    ccff_head = v[31];
    #1;
    total++; if (cfg_done !== 1'b0) $display("FAIL recfg_done_drop got %b exp 0", cfg_done); else passed++;
    total++; if (pad_oe !== 8'h00) $display("FAIL recfg_oe got %h exp 00", pad_oe); else passed++;
    total++; if (fabric_inpad !== 8'h00) $display("FAIL recfg_inpad got %h exp 00", fabric_inpad); else passed++;
    shift_vec(v);
    total++; if (cfg_done !== 1'b1) $display("FAIL recfg_done got %b exp 1", cfg_done); else passed++;
    total++; if (pad_oe !== 8'hFF) $display("FAIL recfg_oe_new got %h exp ff", pad_oe); else passed++;
  endtask

  task automatic test_random();
    logic [34:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      fabric_outpad = 8'($urandom);
      pad_in        = 8'($urandom);
      ccff_head     = 1'($urandom);
      ccff_en       = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (nshift % 32 == 0 && $urandom_range(0, 1) == 0) ccff_en = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        pReset = 1'b0;
        model_reset();
      end else begin
        pReset = 1'b1;
      end
      #1;
      got = {ccff_tail, cfg_done, pad_out, pad_oe, fabric_inpad};
      exp = {chain_m()[31], done_m(), exp_pad_out(), exp_pad_oe(), exp_fabric_inpad()};
      total++; if (got !== exp) $display("FAIL rand_cycle%0d got %h exp %h", n, got, exp); else passed++;
      tick();
    end
    pReset  = 1'b1;
    ccff_en = 1'b0;
  endtask

  initial begin
    pReset        = 1'b0;
    ccff_en       = 1'b0;
    ccff_head     = 1'b0;
    fabric_outpad = '0;
    pad_in        = '0;
    model_reset();
    @(negedge prog_clk);
    test_reset();
    test_load();
    test_reg_inv();
    test_passthrough();
    test_reset_mid();
    test_reconfig();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
